// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues ROM reads against a credit limit, queues returned commands
// with their addresses, and hands them to decode; branch redirect flushes and squashes.
module fetch_prefetch_unit #(
  parameter int unsigned        DATA_W   = 14,
  parameter int unsigned        ADDR_W   = 12,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause_READ,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       rom_rd,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       cmd_valid,
  output logic [DATA_W-1:0]          cmd_data,
  output logic [ADDR_W-1:0]          cmd_addr,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Entries queued plus the read in flight must stay below DEPTH; a same-cycle pop does
  // not count, which keeps the issue path independent of cmd_ready.
  always_comb begin
    credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    rom_rd      = reset & ~pause_READ & ~redirect_valid & (credit_used < (CNT_W + 1)'(DEPTH));
    push        = inflight_q & ~redirect_valid;
    pop         = cmd_valid & cmd_ready & ~redirect_valid;
  end

  always_comb begin
    rom_addr  = pc_q;
    level     = count_q;
    cmd_valid = (count_q != '0);
    cmd_data  = cmd_valid ? mem_data_q[rd_ptr_q] : '0;
    cmd_addr  = cmd_valid ? mem_addr_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else if (redirect_valid) begin
      // The return landing this cycle is dropped along with the queue contents.
      pc_q       <= redirect_addr;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= rom_rd;
      if (rom_rd) begin
        pc_q            <= pc_q + ADDR_W'(1);
        inflight_addr_q <= pc_q;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: cmd_data/cmd_addr are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= inflight_addr_q;
      mem_data_q[wr_ptr_q] <= rom_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: ROM model returns addr+0x100 one cycle after rom_rd;
// a negedge monitor pops the expected-address queue on every accepted command.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause_READ;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        rom_rd;
  logic [11:0] rom_addr;
  logic [13:0] rom_data;
  logic        cmd_valid;
  logic [13:0] cmd_data;
  logic [11:0] cmd_addr;
  logic        cmd_ready;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DATA_W  (14),
    .ADDR_W  (12),
    .DEPTH   (4),
    .RESET_PC(12'h000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pause_READ    (pause_READ),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_addr      (cmd_addr),
    .cmd_ready     (cmd_ready),
    .level         (level)
  );

  initial rom_data = '0;
  always @(posedge clk) begin
    if (rom_rd) rom_data <= {2'b00, rom_addr} + 14'h100;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: a handshake in a redirect cycle is void, so it is not scored.
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got addr %0h data %0h want nothing", cmd_addr, cmd_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("cmd_addr", 32'(cmd_addr), 32'(e));
        chk("cmd_data", 32'(cmd_data), 32'({2'b00, e} + 14'h100));
      end
    end
  end

  task automatic step(input logic rdy, input logic pse, input logic rv, input logic [11:0] ra);
    @(posedge clk);
    #1;
    cmd_ready      = rdy;
    pause_READ     = pse;
    redirect_valid = rv;
    redirect_addr  = ra;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h000);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    cmd_ready      = 1'b1;
    pause_READ     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    for (int a = 0; a < 12; a++) exp_q.push_back(12'(a));
    repeat (2) @(negedge clk);
    check_reset_values();

    // Cycle 1: reset released, first fetch at RESET_PC.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("start_rom_rd", 32'(rom_rd), 32'd1);
    chk("start_rom_addr", 32'(rom_addr), 32'h000);
    chk("start_valid_c1", 32'(cmd_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("start_rom_addr_c2", 32'(rom_addr), 32'h001);
    chk("start_valid_c2", 32'(cmd_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("start_valid_c3", 32'(cmd_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 12'h0);
      chk("stream_valid", 32'(cmd_valid), 32'd1);
      chk("stream_level", 32'(level), 32'd1);
    end

    // Back-pressure, cycles 9..18.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h0);
      if (i == 2) begin
        chk("bp_rom_rd_stop", 32'(rom_rd), 32'd0);
        chk("bp_level3", 32'(level), 32'd3);
      end
      if (i == 3) chk("bp_level_sat", 32'(level), 32'd4);
      if (i == 6) begin
        chk("bp_hold_addr", 32'(cmd_addr), 32'h006);
        chk("bp_hold_data", 32'(cmd_data), 32'h106);
        chk("bp_pc_hold", 32'(rom_addr), 32'h00a);
        chk("bp_rom_rd_idle", 32'(rom_rd), 32'd0);
      end
    end
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("pop_no_credit", 32'(rom_rd), 32'd0);
    chk("bp_level_full", 32'(level), 32'd4);
    repeat (5) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Build level=3 with a read in flight, then redirect (handshake offered but void).
    step(1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b1, 12'h200);
    for (int a = 'h200; a <= 'h207; a++) exp_q.push_back(12'(a));
    chk("redir_pre_level", 32'(level), 32'd3);
    chk("redir_rom_rd", 32'(rom_rd), 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("redir_level0", 32'(level), 32'd0);
    chk("redir_valid0", 32'(cmd_valid), 32'd0);
    chk("redir_rom_rd1", 32'(rom_rd), 32'd1);
    chk("redir_rom_addr", 32'(rom_addr), 32'h200);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("redir_valid_r2", 32'(cmd_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("redir_valid_r3", 32'(cmd_valid), 32'd1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Pause for 5 cycles: no reads, queue drains, PC holds.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 12'h0);
      chk("pause_rom_rd", 32'(rom_rd), 32'd0);
      if (i == 3) begin
        chk("pause_level0", 32'(level), 32'd0);
        chk("pause_valid0", 32'(cmd_valid), 32'd0);
        chk("pause_pc", 32'(rom_addr), 32'h205);
      end
    end
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("resume_rom_rd", 32'(rom_rd), 32'd1);
    chk("resume_addr", 32'(rom_addr), 32'h205);
    repeat (4) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Wrap-around through 0xFFF.
    step(1'b1, 1'b0, 1'b1, 12'hffe);
    exp_q.push_back(12'hffe);
    exp_q.push_back(12'hfff);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h001);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 12'h0);
      if (i == 2) chk("wrap_rom_addr", 32'(rom_addr), 32'h000);
    end

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values();
    for (int a = 0; a < 3; a++) exp_q.push_back(12'(a));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("restart_rom_rd", 32'(rom_rd), 32'd1);
    chk("restart_addr", 32'(rom_addr), 32'h000);
    repeat (4) step(1'b1, 1'b0, 1'b0, 12'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 12'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
